controller_fsm: RTL and testbench

CONTROLLER_FSM -- requirements
Module: controller_fsm

---
 rtl/controller_fsm.sv | 87 ++++++++
 tb/tb_controller_fsm.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/controller_fsm.sv
// controller_fsm: multi-cycle instruction sequencer; s/in start an instruction while w is high, err flags illegal encodings, the rest drive datapath strobes, selects, indices and immediates
module controller_fsm #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic [WIDTH-1:0] in,
  output logic             w,
  output logic             err,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             write,
  output logic             vsel,
  output logic             asel,
  output logic             bsel,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [WIDTH-1:0] sximm5,
  output logic [WIDTH-1:0] sximm8
);
  typedef enum logic [2:0] {WAIT, DECODE, GETA, GETB, ALU, WRITEREG, WRITEIMM} state_t;
  state_t st, ns;
  logic [WIDTH-1:0] ir, nir;
  logic nerr;
  logic mov_imm, mov_sh, alu_op, mvn, cmp;
  logic n_mov_sh, n_alu, n_mvn, n_cmp;
  assign mov_imm = ir[15:13] == 3'b110 && ir[12:11] == 2'b10;
  assign mov_sh  = ir[15:13] == 3'b110 && ir[12:11] == 2'b00;
  assign mvn     = ir[15:13] == 3'b101 && ir[12:11] == 2'b11;
  assign alu_op  = ir[15:13] == 3'b101 && ir[12:11] != 2'b11;
  assign cmp     = ir[15:13] == 3'b101 && ir[12:11] == 2'b01;
  always_comb begin
    ns   = st;
    nir  = ir;
    nerr = err;
    case (st)
      WAIT: if (s) begin
        ns   = DECODE;
        nir  = in;
        nerr = 1'b0;
      end
      DECODE: begin
        ns   = mov_imm ? WRITEIMM : (mov_sh || mvn) ? GETB : alu_op ? GETA : WAIT;
        nerr = !(mov_imm || mov_sh || mvn || alu_op);
      end
      GETA:    ns = GETB;
      GETB:    ns = ALU;
      ALU:     ns = cmp ? WAIT : WRITEREG;
      default: ns = WAIT;
    endcase
    if (reset) begin
      ns   = WAIT;
      nir  = '0;
      nerr = 1'b0;
    end
  end
  // Outputs are registered from the next state and next IR, so they line up with st/ir exactly
  assign n_alu    = nir[15:13] == 3'b101;
  assign n_mov_sh = nir[15:13] == 3'b110 && nir[12:11] == 2'b00;
  assign n_mvn    = n_alu && nir[12:11] == 2'b11;
  assign n_cmp    = n_alu && nir[12:11] == 2'b01;
  always_ff @(posedge clk) begin
    st       <= ns;
    ir       <= nir;
    err      <= nerr;
    w        <= ns == WAIT;
    loada    <= ns == GETA;
    loadb    <= ns == GETB;
    loadc    <= ns == ALU && !n_cmp;
    loads    <= ns == ALU && n_cmp;
    write    <= ns == WRITEREG || ns == WRITEIMM;
    vsel     <= ns == WRITEIMM;
    asel     <= ns == ALU && (n_mov_sh || n_mvn);
    bsel     <= 1'b0;
    readnum  <= ns == GETA ? nir[10:8] : ns == GETB ? nir[2:0] : 3'd0;
    writenum <= ns == WRITEREG ? nir[7:5] : ns == WRITEIMM ? nir[10:8] : 3'd0;
    shift    <= ns == ALU ? nir[4:3] : 2'd0;
    ALUop    <= ns == ALU && n_alu ? nir[12:11] : 2'd0;
  end
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
endmodule

// File: tb/tb_controller_fsm.sv
// tb_controller_fsm: directed self-checking bench for controller_fsm
module tb_controller_fsm;
  logic clk = 1'b0, reset = 1'b1, s = 1'b0;
  logic [15:0] in = '0;
  logic w, err, loada, loadb, loadc, loads, write, vsel, asel, bsel;
  logic [2:0] readnum, writenum;
  logic [1:0] shift, ALUop;
  logic [15:0] sximm5, sximm8;
  logic [7:0] strb;
  int total = 0, bad = 0;
  controller_fsm #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .s(s), .in(in), .w(w), .err(err),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .write(write),
    .vsel(vsel), .asel(asel), .bsel(bsel), .readnum(readnum), .writenum(writenum),
    .shift(shift), .ALUop(ALUop), .sximm5(sximm5), .sximm8(sximm8)
  );
  assign strb = {loada, loadb, loadc, loads, write, vsel, asel, bsel};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [15:0] ins);
    in = ins;
    s = 1'b1;
    step();
    s = 1'b0;
    in = 16'h1234;
  endtask
  initial begin
    step();
    step();
    chk("rst_w", 16'(w), 16'd1);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_strb", 16'(strb), 16'h00);
    chk("rst_idx", {10'd0, readnum, writenum}, 16'd0);
    chk("rst_ctl", {12'd0, shift, ALUop}, 16'd0);
    reset = 1'b0;
    step();
    chk("idle_w", 16'(w), 16'd1);
    accept(16'hD007);
    chk("movi_dec_w", 16'(w), 16'd0);
    chk("movi_dec_strb", 16'(strb), 16'h00);
    step();
    chk("movi_wi_strb", 16'(strb), 16'b0000_1100);
    chk("movi_wi_wn", 16'(writenum), 16'd0);
    chk("movi_sx8", sximm8, 16'h0007);
    chk("movi_sx5", sximm5, 16'h0007);
    step();
    chk("movi_done_w", 16'(w), 16'd1);
    chk("movi_done_strb", 16'(strb), 16'h00);
    accept(16'hA148);
    chk("add_dec_strb", 16'(strb), 16'h00);
    step();
    chk("add_geta_strb", 16'(strb), 16'b1000_0000);
    chk("add_geta_rn", 16'(readnum), 16'd1);
    step();
    chk("add_getb_strb", 16'(strb), 16'b0100_0000);
    chk("add_getb_rn", 16'(readnum), 16'd0);
    step();
    chk("add_alu_strb", 16'(strb), 16'b0010_0000);
    chk("add_alu_shift", 16'(shift), 16'd1);
    chk("add_alu_op", 16'(ALUop), 16'd0);
    step();
    chk("add_wr_strb", 16'(strb), 16'b0000_1000);
    chk("add_wr_wn", 16'(writenum), 16'd2);
    chk("add_wr_w", 16'(w), 16'd0);
    step();
    chk("add_done_w", 16'(w), 16'd1);
    accept(16'hA900);
    chk("cmp_dec_strb", 16'(strb), 16'h00);
    step();
    chk("cmp_geta_strb", 16'(strb), 16'b1000_0000);
    step();
    chk("cmp_getb_strb", 16'(strb), 16'b0100_0000);
    step();
    chk("cmp_alu_strb", 16'(strb), 16'b0001_0000);
    chk("cmp_alu_op", 16'(ALUop), 16'd1);
    chk("cmp_alu_w", 16'(w), 16'd0);
    step();
    chk("cmp_done_w", 16'(w), 16'd1);
    chk("cmp_done_strb", 16'(strb), 16'h00);
    accept(16'hB861);
    step();
    chk("mvn_getb_strb", 16'(strb), 16'b0100_0000);
    chk("mvn_getb_rn", 16'(readnum), 16'd1);
    step();
    chk("mvn_alu_strb", 16'(strb), 16'b0010_0010);
    chk("mvn_alu_op", 16'(ALUop), 16'd3);
    step();
    chk("mvn_wr_strb", 16'(strb), 16'b0000_1000);
    chk("mvn_wr_wn", 16'(writenum), 16'd3);
    step();
    chk("mvn_done_w", 16'(w), 16'd1);
    accept(16'hD0FF);
    chk("sx8_neg", sximm8, 16'hFFFF);
    chk("sx5_neg", sximm5, 16'hFFFF);
    step();
    step();
    chk("sx_done_w", 16'(w), 16'd1);
    accept(16'h0000);
    chk("ill_dec_strb", 16'(strb), 16'h00);
    chk("ill_dec_w", 16'(w), 16'd0);
    step();
    chk("ill_w", 16'(w), 16'd1);
    chk("ill_err", 16'(err), 16'd1);
    chk("ill_strb", 16'(strb), 16'h00);
    step();
    chk("ill_err_sticky", 16'(err), 16'd1);
    accept(16'hD007);
    chk("ill_err_clr", 16'(err), 16'd0);
    step();
    step();
    in = 16'hD007;
    s = 1'b1;
    step();
    chk("b2b_dec_w", 16'(w), 16'd0);
    step();
    chk("b2b_wi_strb", 16'(strb), 16'b0000_1100);
    step();
    chk("b2b_wait_w", 16'(w), 16'd1);
    step();
    chk("b2b_reaccept_w", 16'(w), 16'd0);
    s = 1'b0;
    step();
    step();
    chk("b2b_end_w", 16'(w), 16'd1);
    accept(16'hA148);
    step();
    step();
    chk("rstmid_getb_strb", 16'(strb), 16'b0100_0000);
    reset = 1'b1;
    step();
    chk("rstmid_w", 16'(w), 16'd1);
    chk("rstmid_strb", 16'(strb), 16'h00);
    chk("rstmid_err", 16'(err), 16'd0);
    reset = 1'b0;
    step();
    chk("rstmid_after_strb", 16'(strb), 16'h00);
    chk("rstmid_after_w", 16'(w), 16'd1);
    accept(16'h0000);
    step();
    chk("rst_err_set", 16'(err), 16'd1);
    reset = 1'b1;
    step();
    chk("rst_err_clr", 16'(err), 16'd0);
    chk("rst_sx8", sximm8, 16'h0000);
    reset = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
